ibex_cheri_memchecker_pipe: RTL

// CHERI authority checker for one Ibex memory port (data LSU or instruction fetch) with up to

---
 rtl/ibex_cheri_memchecker_pipe.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ibex_cheri_memchecker_pipe.sv
// CHERI bounds/permission checker for one Ibex memory port. Each granted request is checked
// against the authorising capability and the result is queued in order until its rvalid.
module ibex_cheri_memchecker_pipe #(
  parameter bit          DataMem            = 1'b1,
  parameter int unsigned CheriCapWidth      = 91,
  parameter int unsigned MaxOutstanding     = 2,
  parameter int unsigned PermitExecuteIndex = 1,
  parameter int unsigned CheriExcWidth      = 6
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [CheriCapWidth-1:0]            auth_cap_i,
  input  logic                                data_req_i,
  input  logic                                data_gnt_i,
  input  logic                                data_rvalid_i,
  input  logic [31:0]                         data_addr_i,
  input  logic                                data_we_i,
  input  logic [1:0]                          data_type_i,
  input  logic [3:0]                          data_be_i,
  input  logic                                data_cap_i,
  output logic                                req_stall_o,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic [CheriExcWidth-1:0]            cheri_mem_exc_o,
  output logic                                cap_access_exc_o,
  output logic                                instr_upper_exc_o,
  output logic                                proto_err_o
);

  localparam int unsigned CntW   = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned EntryW = CheriExcWidth + 2;

  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(MaxOutstanding);

  // Exception vector bit positions.
  localparam int unsigned ExcTag    = 0;
  localparam int unsigned ExcSeal   = 1;
  localparam int unsigned ExcExec   = 2;
  localparam int unsigned ExcLoad   = 3;
  localparam int unsigned ExcStore  = 4;
  localparam int unsigned ExcLength = 5;

  localparam int unsigned PermLoad     = 2;
  localparam int unsigned PermStore    = 3;
  localparam int unsigned PermLoadCap  = 4;
  localparam int unsigned PermStoreCap = 5;

  // Capability layout: [90] tag, [89:85] reserved, [84:78] kind, [77:65] perms,
  // [64:32] top (33-bit), [31:0] base.
  logic        cap_tag;
  logic [6:0]  cap_kind;
  logic [12:0] cap_perms;
  logic [32:0] cap_top;
  logic [31:0] cap_base;

  assign cap_tag   = auth_cap_i[90];
  assign cap_kind  = auth_cap_i[84:78];
  assign cap_perms = auth_cap_i[77:65];
  assign cap_top   = auth_cap_i[64:32];
  assign cap_base  = auth_cap_i[31:0];

  logic unused_bits;
  assign unused_bits = ^{auth_cap_i[89:85], cap_perms, data_addr_i[1:0]};

  // Access geometry
  logic [1:0]  be_off;
  logic [3:0]  acc_size;
  logic [31:0] start_addr;
  logic [31:0] upper_addr;
  logic [32:0] end_ext;
  logic [32:0] upper_end;

  always_comb begin
    be_off = 2'd0;
    casez (data_be_i)
      4'b???1: be_off = 2'd0;
      4'b??10: be_off = 2'd1;
      4'b?100: be_off = 2'd2;
      4'b1000: be_off = 2'd3;
      default: be_off = 2'd0;
    endcase
  end

  always_comb begin
    acc_size = 4'd2;
    if (DataMem) begin
      if (data_cap_i) begin
        acc_size = 4'd8;
      end else begin
        unique case (data_type_i)
          2'b00:   acc_size = 4'd4;
          2'b01:   acc_size = 4'd2;
          2'b10:   acc_size = 4'd1;
          default: acc_size = 4'd8;
        endcase
      end
    end
  end

  assign start_addr = DataMem ? {data_addr_i[31:2], be_off} : {data_addr_i[31:2], 2'b00};
  assign upper_addr = {data_addr_i[31:2], 2'b10};
  assign end_ext    = {1'b0, start_addr} + {29'b0, acc_size};
  assign upper_end  = {1'b0, upper_addr} + 33'd2;

  // Check results for the request presented this cycle
  logic [CheriExcWidth-1:0] exc_vec;
  logic                     cap_exc;
  logic                     upper_exc;
  logic [EntryW-1:0]        entry_in;

  // Load/store permissions only apply to the data port; fetches check execute instead.
  always_comb begin
    exc_vec            = '0;
    exc_vec[ExcTag]    = ~cap_tag;
    exc_vec[ExcSeal]   = |cap_kind[6:4];
    exc_vec[ExcExec]   = ~DataMem & ~cap_perms[PermitExecuteIndex];
    exc_vec[ExcLoad]   = DataMem & ~data_we_i & ~cap_perms[PermLoad];
    exc_vec[ExcStore]  = DataMem & data_we_i & ~cap_perms[PermStore];
    exc_vec[ExcLength] = (start_addr < cap_base) | (end_ext > cap_top);
  end

  assign cap_exc = DataMem & data_cap_i &
                   ((start_addr[2:0] != 3'b000) |
                    (~data_we_i & ~cap_perms[PermLoadCap]) |
                    (data_we_i & ~cap_perms[PermStoreCap]));

  assign upper_exc = ~DataMem & (upper_end > cap_top);
  assign entry_in  = {exc_vec, cap_exc, upper_exc};

  // Result FIFO
  logic [EntryW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              proto_err_q, proto_err_d;
  logic              push, empty, full, do_pop, do_push;

  assign push    = data_req_i & data_gnt_i;
  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCnt);
  assign do_pop  = data_rvalid_i & ~empty;
  // A pop in the same cycle frees the slot for a push into a full FIFO.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    proto_err_d = proto_err_q;
    if (do_push) begin
      wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if ((push & full & ~data_rvalid_i) | (data_rvalid_i & empty)) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
      if (do_push) begin
        fifo_q[wptr_q] <= entry_in;
      end
    end
  end

  // Outputs
  logic [EntryW-1:0] head;
  assign head = fifo_q[rptr_q];

  assign cheri_mem_exc_o   = do_pop ? head[EntryW-1:2] : '0;
  assign cap_access_exc_o  = do_pop & head[1];
  assign instr_upper_exc_o = do_pop & head[0];
  assign req_stall_o       = full;
  assign outstanding_o     = count_q;
  assign proto_err_o       = proto_err_q;

endmodule
